// File: rtl/handshake_constant_sink.sv
// handshake_constant_sink: valid/ready sink that checks every accepted token against a constant, counts tokens and stalls ready on a programmable pattern
module handshake_constant_sink #(
    parameter int                    DATA_WIDTH   = 37,
    parameter logic [DATA_WIDTH-1:0] EXPECTED     = 37'h0DD4A70553,
    parameter int                    STALL_CYCLES = 0,
    parameter int                    MAX_TOKENS   = 0,
    parameter int                    COUNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  ins,
    input  logic                   ins_valid,
    output logic                   ins_ready,
    output logic [COUNT_WIDTH-1:0] token_count,
    output logic                   mismatch,
    output logic [DATA_WIDTH-1:0]  first_bad,
    output logic                   done
);
    localparam int SW = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
    localparam logic [SW-1:0] STALL_LOAD = SW'((STALL_CYCLES > 0) ? STALL_CYCLES - 1 : 0);
    // A limit beyond the saturated count can never be hit, so done is simply never raised.
    localparam bit MAX_REACHABLE = (MAX_TOKENS > 0) &&
                                   (longint'(MAX_TOKENS) < (longint'(1) << COUNT_WIDTH));
    localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = COUNT_WIDTH'(MAX_TOKENS);

    typedef enum logic [1:0] {ACCEPT, STALL, DONE} state_t;

    state_t                  state_q, state_d;
    logic [SW-1:0]           stall_q, stall_d;
    logic [COUNT_WIDTH-1:0]  count_q, count_d;
    logic                    mismatch_q, mismatch_d;
    logic [DATA_WIDTH-1:0]   first_bad_q, first_bad_d;
    logic                    done_q, done_d;
    logic                    xfer;

    // Ready comes only from state and reset, never from ins_valid.
    assign ins_ready   = rst && (state_q == ACCEPT);
    assign xfer        = ins_valid && ins_ready;
    assign token_count = count_q;
    assign mismatch    = mismatch_q;
    assign first_bad   = first_bad_q;
    assign done        = done_q;

    // Next-state, stall countdown, saturating count and payload checking.
    always_comb begin
        state_d     = state_q;
        stall_d     = stall_q;
        count_d     = count_q;
        mismatch_d  = mismatch_q;
        first_bad_d = first_bad_q;
        if (xfer && (count_q != '1))
            count_d = count_q + COUNT_WIDTH'(1);
        if (xfer && (ins != EXPECTED)) begin
            mismatch_d = 1'b1;
            if (!mismatch_q)
                first_bad_d = ins;
        end
        case (state_q)
            ACCEPT: begin
                if (xfer) begin
                    if (MAX_REACHABLE && (count_d == MAX_COUNT)) begin
                        state_d = DONE;
                    end else if (STALL_CYCLES != 0) begin
                        state_d = STALL;
                        stall_d = STALL_LOAD;
                    end
                end
            end
            STALL: begin
                if (stall_q == '0)
                    state_d = ACCEPT;
                else
                    stall_d = stall_q - SW'(1);
            end
            DONE:    state_d = DONE;
            default: state_d = ACCEPT;
        endcase
        done_d = (state_d == DONE);
    end

    // State and registered outputs, cleared asynchronously while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ACCEPT;
            stall_q     <= '0;
            count_q     <= '0;
            mismatch_q  <= 1'b0;
            first_bad_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_q     <= stall_d;
            count_q     <= count_d;
            mismatch_q  <= mismatch_d;
            first_bad_q <= first_bad_d;
            done_q      <= done_d;
        end
    end
endmodule
